// File: rtl/rsa_avalon_arbiter.sv
// rsa_avalon_arbiter: round-robin arbiter sharing one Avalon-MM slave port
// between the RSA core master (r0) and the host-side master (r1), with a
// waitrequest watchdog that force-completes transfers stuck on a hung slave.
module rsa_avalon_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic [DATA_W-1:0] r0_readdata,
    output logic              r0_waitrequest,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic [DATA_W-1:0] r1_readdata,
    output logic              r1_waitrequest,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_waitrequest,
    input  logic              err_clear,
    output logic              timeout_err
);

    // A zero TIMEOUT still gets a 1-bit counter so the logic stays legal;
    // the comparison against TIMEOUT is then disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               last_grant;
    logic               last_grant_next;
    logic [CNT_W-1:0]   wd_cnt;
    logic [CNT_W-1:0]   wd_cnt_next;
    logic               set_err;

    logic               req0;
    logic               req1;
    logic               granted;
    logic               sel1;
    logic               cur_read;
    logic               cur_write;
    logic               cur_req;
    logic [ADDR_W-1:0]  cur_address;
    logic [DATA_W-1:0]  cur_writedata;
    logic               forced;
    logic               completion;

    assign req0    = r0_read | r0_write;
    assign req1    = r1_read | r1_write;
    assign granted = (state == GNT0) || (state == GNT1);
    assign sel1    = (state == GNT1);

    // Select the granted requester's command; forced completion depends only
    // on the registered counter and requester inputs, never on s_waitrequest.
    always_comb begin
        cur_read      = sel1 ? r1_read      : r0_read;
        cur_write     = sel1 ? r1_write     : r0_write;
        cur_address   = sel1 ? r1_address   : r0_address;
        cur_writedata = sel1 ? r1_writedata : r0_writedata;
        cur_req       = cur_read | cur_write;
        forced        = (TIMEOUT > 0) && granted && cur_req &&
                        (wd_cnt == CNT_W'(TIMEOUT));
    end

    // Slave-side and requester-side outputs; idle drives a quiet bus.
    always_comb begin
        s_address      = '0;
        s_writedata    = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        r0_waitrequest = 1'b1;
        r1_waitrequest = 1'b1;
        r0_readdata    = s_readdata;
        r1_readdata    = s_readdata;
        if (granted) begin
            s_address   = cur_address;
            s_writedata = cur_writedata;
            s_write     = cur_write & ~forced;
            s_read      = cur_read & ~cur_write & ~forced;
            if (sel1) begin
                r1_waitrequest = forced ? 1'b0 : s_waitrequest;
                if (forced) begin
                    r1_readdata = '0;
                end
            end else begin
                r0_waitrequest = forced ? 1'b0 : s_waitrequest;
                if (forced) begin
                    r0_readdata = '0;
                end
            end
        end
    end

    assign completion = (s_read | s_write) & ~s_waitrequest;

    // Arbitration, transfer completion and watchdog counting.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        wd_cnt_next     = wd_cnt;
        set_err         = 1'b0;
        case (state)
            IDLE: begin
                wd_cnt_next = '0;
                if (req0 && req1) begin
                    state_next = last_grant ? GNT0 : GNT1;
                end else if (req0) begin
                    state_next = GNT0;
                end else if (req1) begin
                    state_next = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!cur_req) begin
                    state_next  = IDLE;
                    wd_cnt_next = '0;
                end else if (forced) begin
                    state_next      = IDLE;
                    last_grant_next = sel1;
                    wd_cnt_next     = '0;
                    set_err         = 1'b1;
                end else if (completion) begin
                    state_next      = IDLE;
                    last_grant_next = sel1;
                    wd_cnt_next     = '0;
                end else if (s_waitrequest) begin
                    wd_cnt_next = wd_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                wd_cnt_next = '0;
            end
        endcase
    end

    // State, round-robin pointer and watchdog registers; r0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            wd_cnt     <= wd_cnt_next;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (set_err) begin
            timeout_err <= 1'b1;
        end else if (err_clear) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rsa_avalon_arbiter.sv
// tb_rsa_avalon_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the shared memory and fairness rules.
module tb_rsa_avalon_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] r0_address;
    logic        r0_read;
    logic        r0_write;
    logic [7:0]  r0_writedata;
    logic [7:0]  r0_readdata;
    logic        r0_waitrequest;
    logic [31:0] r1_address;
    logic        r1_read;
    logic        r1_write;
    logic [7:0]  r1_writedata;
    logic [7:0]  r1_readdata;
    logic        r1_waitrequest;
    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [7:0]  s_writedata;
    logic [7:0]  s_readdata;
    logic        s_waitrequest;
    logic        err_clear;
    logic        timeout_err;

    int total;
    int bad;

    rsa_avalon_arbiter #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(8)) dut (
        .clk(clk),
        .reset(reset),
        .r0_address(r0_address),
        .r0_read(r0_read),
        .r0_write(r0_write),
        .r0_writedata(r0_writedata),
        .r0_readdata(r0_readdata),
        .r0_waitrequest(r0_waitrequest),
        .r1_address(r1_address),
        .r1_read(r1_read),
        .r1_write(r1_write),
        .r1_writedata(r1_writedata),
        .r1_readdata(r1_readdata),
        .r1_waitrequest(r1_waitrequest),
        .s_address(s_address),
        .s_read(s_read),
        .s_write(s_write),
        .s_writedata(s_writedata),
        .s_readdata(s_readdata),
        .s_waitrequest(s_waitrequest),
        .err_clear(err_clear),
        .timeout_err(timeout_err)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required to finish");
        $fatal(1, "[TB] global time limit exceeded");
    end

    task automatic idle_inputs();
        r0_address = '0; r0_read = 0; r0_write = 0; r0_writedata = '0;
        r1_address = '0; r1_read = 0; r1_write = 0; r1_writedata = '0;
        s_readdata = '0; s_waitrequest = 0; err_clear = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        total++; if (s_read !== 1'b0 || s_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_cmd: got rd=%b wr=%b, required 0 0", s_read, s_write); end
        total++; if (r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL reset_wait: got %b %b, required 1 1", r0_waitrequest, r1_waitrequest); end
        total++; if (s_address !== 32'h0 || s_writedata !== 8'h0) begin bad++; $display("[TB] FAIL reset_bus: got addr=%h wd=%h, required 0 0", s_address, s_writedata); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b, required 0", timeout_err); end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        r0_read = 1; r0_address = 32'h0000_0010; s_readdata = 8'hA5; s_waitrequest = 0;
        #1;
        total++; if (s_read !== 1'b0 || r0_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL single_idle: got rd=%b w0=%b, required 0 1", s_read, r0_waitrequest); end
        @(negedge clk);
        #1;
        total++; if (s_read !== 1'b1 || s_address !== 32'h10) begin bad++; $display("[TB] FAIL single_cmd: got rd=%b addr=%h, required 1 00000010", s_read, s_address); end
        total++; if (r0_waitrequest !== 1'b0 || r0_readdata !== 8'hA5) begin bad++; $display("[TB] FAIL single_data: got w0=%b rd=%h, required 0 a5", r0_waitrequest, r0_readdata); end
        total++; if (r1_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL single_r1wait: got %b, required 1", r1_waitrequest); end
        @(negedge clk);
        r0_read = 0;
        #1;
        total++; if (s_read !== 1'b0) begin bad++; $display("[TB] FAIL single_once: got s_read=%b, required 0", s_read); end
    endtask

    task automatic test_contention();
        reset = 1;
        @(negedge clk);
        reset = 0;
        r0_write = 1; r0_address = 32'd4; r0_writedata = 8'h11;
        r1_write = 1; r1_address = 32'd8; r1_writedata = 8'h22;
        s_waitrequest = 0;
        #1;
        total++; if (s_write !== 1'b0) begin bad++; $display("[TB] FAIL cont_idle: got s_write=%b, required 0", s_write); end
        @(negedge clk);
        #1;
        total++; if (s_write !== 1'b1 || s_address !== 32'd4 || s_writedata !== 8'h11) begin bad++; $display("[TB] FAIL cont_first: got wr=%b addr=%h wd=%h, required 1 4 11", s_write, s_address, s_writedata); end
        total++; if (r0_waitrequest !== 1'b0 || r1_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL cont_first_wait: got %b %b, required 0 1", r0_waitrequest, r1_waitrequest); end
        @(negedge clk);
        r0_write = 0;
        #1;
        total++; if (s_write !== 1'b0 || r1_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL cont_slot: got wr=%b w1=%b, required 0 1", s_write, r1_waitrequest); end
        @(negedge clk);
        #1;
        total++; if (s_write !== 1'b1 || s_address !== 32'd8 || s_writedata !== 8'h22 || r1_waitrequest !== 1'b0) begin bad++; $display("[TB] FAIL cont_second: got wr=%b addr=%h wd=%h w1=%b, required 1 8 22 0", s_write, s_address, s_writedata, r1_waitrequest); end
        @(negedge clk);
        r1_write = 0;
        #1;
        total++; if (s_write !== 1'b0) begin bad++; $display("[TB] FAIL cont_end: got s_write=%b, required 0", s_write); end
    endtask

    task automatic test_back_to_back();
        int n0;
        int n1;
        int exp_who;
        int got_who;
        n0 = 0; n1 = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            r0_read  = (n0 < 6); r0_address = 32'h100 + 32'(n0);
            r1_write = (n1 < 6); r1_address = 32'h200 + 32'(n1); r1_writedata = 8'(n1);
            s_waitrequest = 0; s_readdata = 8'h3C;
            #1;
            exp_who = (c % 2 == 0) ? -1 : (((c - 1) / 2) % 2);
            got_who = -1;
            if (r0_read && !r0_waitrequest) begin got_who = 0; n0++; end
            if (r1_write && !r1_waitrequest) got_who = (got_who == 0) ? 2 : 1;
            if (got_who == 1 || got_who == 2) n1++;
            total++; if (got_who !== exp_who) begin bad++; $display("[TB] FAIL b2b_grant c=%0d: got %0d, required %0d", c, got_who, exp_who); end
        end
        @(negedge clk);
        r0_read = 0; r1_write = 0;
        total++; if (n0 + n1 !== 12) begin bad++; $display("[TB] FAIL b2b_count: got %0d completions, required 12", n0 + n1); end
    endtask

    task automatic test_slave_stall();
        @(negedge clk);
        r1_read = 1; r1_address = 32'h20; s_waitrequest = 1; s_readdata = 8'h00;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            r0_write = 1; r0_address = 32'h40; r0_writedata = 8'h77; s_waitrequest = 1;
            #1;
            total++; if (r1_waitrequest !== 1'b1 || r0_waitrequest !== 1'b1 || s_read !== 1'b1) begin bad++; $display("[TB] FAIL stall_hold c=%0d: got w1=%b w0=%b rd=%b, required 1 1 1", c, r1_waitrequest, r0_waitrequest, s_read); end
        end
        @(negedge clk);
        s_waitrequest = 0; s_readdata = 8'h5A;
        #1;
        total++; if (r1_waitrequest !== 1'b0 || r1_readdata !== 8'h5A || r0_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL stall_release: got w1=%b d=%h w0=%b, required 0 5a 1", r1_waitrequest, r1_readdata, r0_waitrequest); end
        @(negedge clk);
        r1_read = 0;
        #1;
        total++; if (s_write !== 1'b0 || r0_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL stall_slot: got wr=%b w0=%b, required 0 1", s_write, r0_waitrequest); end
        @(negedge clk);
        #1;
        total++; if (s_write !== 1'b1 || r0_waitrequest !== 1'b0 || s_address !== 32'h40) begin bad++; $display("[TB] FAIL stall_r0: got wr=%b w0=%b addr=%h, required 1 0 40", s_write, r0_waitrequest, s_address); end
        @(negedge clk);
        r0_write = 0;
    endtask

    task automatic test_watchdog();
        @(negedge clk);
        r0_write = 1; r0_address = 32'h50; r0_writedata = 8'h99; s_waitrequest = 1; s_readdata = 8'hFF;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            r1_read = 1; r1_address = 32'h60;
            #1;
            total++; if (r0_waitrequest !== 1'b1 || s_write !== 1'b1) begin bad++; $display("[TB] FAIL wd_stall c=%0d: got w0=%b wr=%b, required 1 1", c, r0_waitrequest, s_write); end
        end
        @(negedge clk);
        #1;
        total++; if (s_write !== 1'b0 || s_read !== 1'b0 || r0_waitrequest !== 1'b0 || r0_readdata !== 8'h00) begin bad++; $display("[TB] FAIL wd_force: got wr=%b rd=%b w0=%b d=%h, required 0 0 0 00", s_write, s_read, r0_waitrequest, r0_readdata); end
        total++; if (r1_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL wd_force_r1: got %b, required 1", r1_waitrequest); end
        @(negedge clk);
        r0_write = 0;
        #1;
        total++; if (timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL wd_flag: got %b, required 1", timeout_err); end
        @(negedge clk);
        s_waitrequest = 0; s_readdata = 8'h6B;
        #1;
        total++; if (s_read !== 1'b1 || r1_waitrequest !== 1'b0 || r1_readdata !== 8'h6B) begin bad++; $display("[TB] FAIL wd_r1: got rd=%b w1=%b d=%h, required 1 0 6b", s_read, r1_waitrequest, r1_readdata); end
        @(negedge clk);
        r1_read = 0; err_clear = 1;
        #1;
        total++; if (timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL wd_sticky: got %b, required 1", timeout_err); end
        @(negedge clk);
        err_clear = 0;
        #1;
        total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL wd_clear: got %b, required 0", timeout_err); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        r0_read = 1; r0_address = 32'h70; s_waitrequest = 1;
        @(negedge clk);
        r1_read = 1; r1_address = 32'h80;
        #1;
        total++; if (s_read !== 1'b1 || r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL rmid_gnt: got rd=%b w0=%b w1=%b, required 1 1 1", s_read, r0_waitrequest, r1_waitrequest); end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        total++; if (s_read !== 1'b0 || r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL rmid_idle: got rd=%b w0=%b w1=%b, required 0 1 1", s_read, r0_waitrequest, r1_waitrequest); end
        @(negedge clk);
        s_waitrequest = 0; s_readdata = 8'h12;
        #1;
        total++; if (r0_waitrequest !== 1'b0 || r1_waitrequest !== 1'b1 || s_address !== 32'h70) begin bad++; $display("[TB] FAIL rmid_tie: got w0=%b w1=%b addr=%h, required 0 1 70", r0_waitrequest, r1_waitrequest, s_address); end
        @(negedge clk);
        r0_read = 0;
        @(negedge clk);
        #1;
        total++; if (r1_waitrequest !== 1'b0 || s_address !== 32'h80) begin bad++; $display("[TB] FAIL rmid_r1: got w1=%b addr=%h, required 0 80", r1_waitrequest, s_address); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        logic        v [2];
        logic        w [2];
        logic [31:0] a [2];
        logic [7:0]  d [2];
        int          age [2];
        int          foreign [2];
        logic        done [2];
        logic [7:0]  slave_mem [16];
        logic [7:0]  ref_mem [16];
        logic [7:0]  rdata;
        int          stall_run;
        int          ncomp;
        stall_run = 0; ncomp = 0;
        for (int i = 0; i < 16; i++) begin slave_mem[i] = '0; ref_mem[i] = '0; end
        for (int r = 0; r < 2; r++) begin v[r] = 0; w[r] = 0; a[r] = '0; d[r] = '0; age[r] = 0; foreign[r] = 0; end
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!v[r] && cyc < 380 && $urandom_range(0, 9) < 6) begin
                    v[r] = 1; w[r] = 1'($urandom_range(0, 1));
                    a[r] = 32'($urandom_range(0, 15)); d[r] = 8'($urandom);
                    age[r] = 0; foreign[r] = 0;
                end
            end
            r0_read = v[0] & ~w[0]; r0_write = v[0] & w[0]; r0_address = a[0]; r0_writedata = d[0];
            r1_read = v[1] & ~w[1]; r1_write = v[1] & w[1]; r1_address = a[1]; r1_writedata = d[1];
            s_waitrequest = (stall_run < 3) && ($urandom_range(0, 3) == 0);
            stall_run = s_waitrequest ? stall_run + 1 : 0;
            #1;
            s_readdata = slave_mem[s_address[3:0]];
            #1;
            done[0] = v[0] && !r0_waitrequest;
            done[1] = v[1] && !r1_waitrequest;
            total++; if (done[0] && done[1]) begin bad++; $display("[TB] FAIL rnd_exclusive cyc=%0d: got both done, required at most one", cyc); end
            for (int r = 0; r < 2; r++) begin
                if (done[r]) begin
                    ncomp++;
                    rdata = (r == 0) ? r0_readdata : r1_readdata;
                    total++; if (s_address !== a[r] || s_write !== w[r] || s_read !== !w[r]) begin bad++; $display("[TB] FAIL rnd_cmd r%0d cyc=%0d: got addr=%h rd=%b wr=%b, required addr=%h wr=%b", r, cyc, s_address, s_read, s_write, a[r], w[r]); end
                    if (w[r]) begin
                        total++; if (s_writedata !== d[r]) begin bad++; $display("[TB] FAIL rnd_wdata r%0d cyc=%0d: got %h, required %h", r, cyc, s_writedata, d[r]); end
                        ref_mem[a[r][3:0]] = d[r];
                    end else begin
                        total++; if (rdata !== ref_mem[a[r][3:0]]) begin bad++; $display("[TB] FAIL rnd_rdata r%0d cyc=%0d: got %h, required %h", r, cyc, rdata, ref_mem[a[r][3:0]]); end
                    end
                    total++; if (foreign[r] > 1) begin bad++; $display("[TB] FAIL rnd_fair r%0d cyc=%0d: got %0d foreign transfers, required <= 1", r, cyc, foreign[r]); end
                end
            end
            if (s_write && !s_waitrequest) slave_mem[s_address[3:0]] = s_writedata;
            if (done[0] && v[1]) foreign[1]++;
            if (done[1] && v[0]) foreign[0]++;
            for (int r = 0; r < 2; r++) begin
                if (done[r]) v[r] = 0;
                else if (v[r]) begin
                    age[r]++;
                    if (age[r] > 40) begin
                        bad++; total++;
                        $display("[TB] FAIL rnd_starve r%0d cyc=%0d: waited %0d cycles, required <= 40", r, cyc, age[r]);
                        v[r] = 0;
                    end
                end
            end
        end
        total++; if (v[0] || v[1]) begin bad++; $display("[TB] FAIL rnd_drain: got pending %b %b, required 0 0", v[0], v[1]); end
        total++; if (ncomp < 50) begin bad++; $display("[TB] FAIL rnd_progress: got %0d completions, required >= 50", ncomp); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL rnd_err: got %b, required 0", timeout_err); end
        @(negedge clk);
        idle_inputs();
    endtask

    // Run all scenarios in order, then report
    initial begin
        total = 0;
        bad = 0;
        reset = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_slave_stall();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_avalon_arbiter.md
# rsa_avalon_arbiter

Two-requester Avalon-MM arbiter that shares one 8-bit-data, 32-bit-address slave port between the RSA core master and the host-side master.

- Round-robin, one transfer per grant, with a one-cycle arbitration slot.
- A waitrequest watchdog prevents a hung slave from deadlocking either requester.
- Sits between the RSA datapath's m0 master, the PCIe-side master and the shared memory-mapped slave in the top-level system.

## Interface
Parameters:
- ADDR_W, 32, address width of all three ports
- DATA_W, 8, data width of all three ports
- TIMEOUT, 1024, max cycles a granted transfer may stall on s_waitrequest; 0 disables the watchdog

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- r0_address / r1_address  in  ADDR_W  requester address (r0 = RSA core, r1 = host)
- r0_read / r1_read  in  1  read request
- r0_write / r1_write  in  1  write request
- r0_writedata / r1_writedata  in  DATA_W  write data
- r0_readdata / r1_readdata  out  DATA_W  read data
- r0_waitrequest / r1_waitrequest  out  1  stall to requester
- s_address  out  ADDR_W  slave address
- s_read  out  1  slave read
- s_write  out  1  slave write
- s_writedata  out  DATA_W  slave write data
- s_readdata  in  DATA_W  slave read data
- s_waitrequest  in  1  slave stall
- err_clear  in  1  clears timeout_err
- timeout_err  out  1  sticky watchdog flag

## Operation
**State machine (registered state): IDLE, GNT0, GNT1.**
- **Request definition:** reqN = rN_read | rN_write.
- **IDLE:**
  - Only req0 → GNT0. Only req1 → GNT1.
  - Both → grant the requester that is not last_grant.
  - Neither → stay in IDLE.
- **GNTx:** slave outputs are a combinational copy of requester x's inputs.
  - rx_waitrequest = s_waitrequest; the other requester's waitrequest = 1.
  - Completion cycle = (s_read | s_write) & ~s_waitrequest.
  - On completion: last_grant <= x, timeout counter <= 0, next state IDLE.
- **Requester drops read and write while granted (protocol violation):** next state IDLE, last_grant unchanged, no completion.
- **Read and write both asserted by a requester:** write has precedence; s_read = 0, s_write = 1.
- **Read data routing:** rN_readdata = s_readdata for both requesters (broadcast). The data is valid only to the requester whose waitrequest is low.
- **Watchdog (TIMEOUT > 0):**
  - Counter increments each GNTx cycle that has s_waitrequest = 1.
  - When the counter reaches TIMEOUT, that cycle is a forced completion:
    - s_read = s_write = 0;
    - rx_waitrequest = 0;
    - rx_readdata = 0;
    - timeout_err <= 1;
    - last_grant <= x;
    - next state IDLE.
  - Counter width is clog2(TIMEOUT+1).
- **timeout_err:** err_clear = 1 clears it. If a timeout fires in the same cycle as err_clear, set wins.

## Timing
**Reset (synchronous, takes effect on the clk edge where reset = 1):**
- State IDLE, last_grant = 1 (r0 wins the first tie), watchdog counter 0, timeout_err 0.
- Resulting outputs: s_read = s_write = 0, r0/r1_waitrequest = 1, s_address/s_writedata = 0.
- Reset during GNTx aborts the transfer. The slave sees read/write drop on the following cycle; the requester sees waitrequest = 1.

**Outputs in IDLE:**
- s_read = s_write = 0; s_address and s_writedata = 0.
- Both waitrequests = 1.

**Latency:**
- Request asserted at cycle t in IDLE → grant state at t+1, and s_read/s_write asserted at t+1.
- With s_waitrequest = 0 at t+1, the transfer completes at t+1 and the state returns to IDLE at t+2.
- Minimum 2 cycles per transfer; peak throughput is one transfer per 2 cycles.

**Requester rule:** requesters hold address, data and command until their waitrequest is low, as Avalon requires. The arbiter never samples requester inputs in IDLE other than to arbitrate.

**Fairness:** with both requesters continuously requesting, grants alternate 0,1,0,1. Neither requester waits more than one foreign transfer.

**Timeout latency:** a stall starting at the grant cycle is forced complete after TIMEOUT cycles with waitrequest high.

**No combinational path from s_waitrequest to s_read/s_write.** The only such paths are from state and requester inputs.

## Test plan
- **Single read:** r0 reads 0x0000_0010, slave returns 0xA5 with 0 wait cycles → s_read high exactly 1 cycle (t+1); r0_readdata = 0xA5 with r0_waitrequest low at t+1; r1_waitrequest stays 1.
- **Contention after reset:** r0 and r1 write simultaneously (0x11 to addr 4, 0x22 to addr 8) → r0 granted first, r1 second; slave sees writes in order 0x11@4 then 0x22@8, 4 cycles total.
- **Continuous dual requests:** 6 transfers each from r0 and r1 → grant sequence strictly alternates, 12 completions in 24 cycles.
- **Slave stall:** 3-cycle s_waitrequest on an r1 read → r1_waitrequest mirrors the slave for 3 cycles, then low with data; r0 requesting meanwhile remains stalled and is granted the cycle after r1 returns to IDLE.
- **Watchdog:** TIMEOUT = 8, slave holds waitrequest forever on an r0 write → forced completion after 8 stalled cycles, timeout_err = 1, r1 then served normally; err_clear pulse → timeout_err = 0.
- **Reset mid-transfer:** reset asserted during a stalled GNT0 read → next cycle IDLE, s_read = 0, both waitrequests 1, first post-reset tie granted to r0.
